// File: rtl/sr_ff_driver_if.sv
// sr_ff_driver_if
//   Request handshake between control logic and sr_ff_driver.
//   req_valid  request present (held stable until accepted)
//   req_level  requested flop level, 1 = set, 0 = reset
//   req_ready  driver can accept a request this cycle
//   modport master : requester side
//   modport slave  : driver side
interface sr_ff_driver_if;
  logic req_valid;
  logic req_level;
  logic req_ready;

  modport master (
    output req_valid,
    output req_level,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_level,
    output req_ready
  );
endinterface

// File: rtl/sr_ff_driver.sv
// sr_ff_driver
//   Command-side driver for a clocked set/reset flop. Turns level requests into
//   s/r pulse sequences of PULSE_W cycles, checks the flop readback one cycle
//   after the pulse and then idles GAP_W cycles before taking the next request.
//   Requests matching the last commanded level are absorbed without a pulse.
//
//   Ports
//     clk       clock, rising edge
//     n_rst     asynchronous active-low reset
//     req_if    request handshake (slave side)
//     s, r      registered set/reset commands to the flop, never both high
//     q_fb      flop output readback
//     err_clr   clears the sticky err flag
//     busy      high while a command is in progress
//     err       sticky readback mismatch flag
//     cmd_cnt   commands issued, wraps
//     skip_cnt  redundant requests absorbed, wraps
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   PULSE | s or r asserted for PULSE_W cycles
//   CHECK | pulse finished, readback compared against the commanded level
//   GAP   | GAP_W idle cycles before the next request can be accepted
module sr_ff_driver #(
  parameter int unsigned PULSE_W   = 2,
  parameter int unsigned GAP_W     = 1,
  parameter bit          HOLD_MODE = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  sr_ff_driver_if.slave    req_if,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  input  logic             err_clr,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cmd_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  // One down-counter serves both PULSE and GAP, sized for the longer of the two.
  localparam int unsigned TMR_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = (GAP_W == 0) ? '0 : TMR_W'(GAP_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic             shadow;
  logic             shadow_valid;
  logic             accept;
  logic             redundant;

  assign accept    = req_if.req_valid && req_if.req_ready;
  assign redundant = shadow_valid && (req_if.req_level == shadow);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      tmr              <= '0;
      shadow           <= 1'b0;
      shadow_valid     <= 1'b0;
      s                <= 1'b0;
      r                <= 1'b0;
      busy             <= 1'b0;
      err              <= 1'b0;
      cmd_cnt          <= '0;
      skip_cnt         <= '0;
      req_if.req_ready <= 1'b1;
    end else begin
      // A mismatch in CHECK below overrides this clear in the same cycle.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (redundant) begin
              skip_cnt <= skip_cnt + CNT_W'(1);
            end else begin
              shadow           <= req_if.req_level;
              shadow_valid     <= 1'b1;
              cmd_cnt          <= cmd_cnt + CNT_W'(1);
              tmr              <= PULSE_LD;
              state            <= PULSE;
              busy             <= 1'b1;
              req_if.req_ready <= 1'b0;
              // s and r swap on the same edge, so a held s drops exactly when r rises.
              s                <= req_if.req_level;
              r                <= ~req_if.req_level;
            end
          end
        end

        PULSE: begin
          if (tmr == '0) begin
            state <= CHECK;
            r     <= 1'b0;
            // In hold mode a set keeps s asserted until the next reset command.
            s     <= HOLD_MODE ? s : 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        CHECK: begin
          if (q_fb != shadow) begin
            err <= 1'b1;
          end
          if (GAP_W == 0) begin
            state            <= IDLE;
            busy             <= 1'b0;
            req_if.req_ready <= 1'b1;
          end else begin
            state <= GAP;
            tmr   <= GAP_LD;
          end
        end

        GAP: begin
          if (tmr == '0) begin
            state            <= IDLE;
            busy             <= 1'b0;
            req_if.req_ready <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: begin
          state            <= IDLE;
          s                <= 1'b0;
          r                <= 1'b0;
          busy             <= 1'b0;
          req_if.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ff_driver.sv
// tb_sr_ff_driver
//   Three driver instances share one request stream: a pulse-mode instance with
//   8-bit counters (main), a hold-mode instance, and a pulse-mode instance with
//   2-bit counters. Each request pushes its hand-computed expectation into a
//   queue; a negedge monitor pops it when the main instance returns to ready.
module tb_sr_ff_driver;

  logic clk;
  logic n_rst;
  logic err_clr;
  int   q_sel;  // main readback: 0 follow flop model, 1 tie high, 2 tie low

  sr_ff_driver_if ifc_m ();
  sr_ff_driver_if ifc_h ();
  sr_ff_driver_if ifc_c ();

  assign ifc_h.req_valid = ifc_m.req_valid;
  assign ifc_h.req_level = ifc_m.req_level;
  assign ifc_c.req_valid = ifc_m.req_valid;
  assign ifc_c.req_level = ifc_m.req_level;

  logic       s_m, r_m, busy_m, err_m, q_m, qfb_m;
  logic [7:0] cmd_m, skip_m;
  logic       s_h, r_h, busy_h, err_h, q_h;
  logic [7:0] cmd_h, skip_h;
  logic       s_c, r_c, busy_c, err_c, q_c;
  logic [1:0] cmd_c, skip_c;

  assign qfb_m = (q_sel == 1) ? 1'b1 : (q_sel == 2) ? 1'b0 : q_m;

  sr_ff_driver #(.PULSE_W(2), .GAP_W(1), .HOLD_MODE(1'b0), .CNT_W(8)) u_main (
    .clk(clk), .n_rst(n_rst), .req_if(ifc_m.slave), .s(s_m), .r(r_m), .q_fb(qfb_m),
    .err_clr(err_clr), .busy(busy_m), .err(err_m), .cmd_cnt(cmd_m), .skip_cnt(skip_m));

  sr_ff_driver #(.PULSE_W(2), .GAP_W(1), .HOLD_MODE(1'b1), .CNT_W(8)) u_hold (
    .clk(clk), .n_rst(n_rst), .req_if(ifc_h.slave), .s(s_h), .r(r_h), .q_fb(q_h),
    .err_clr(err_clr), .busy(busy_h), .err(err_h), .cmd_cnt(cmd_h), .skip_cnt(skip_h));

  sr_ff_driver #(.PULSE_W(2), .GAP_W(1), .HOLD_MODE(1'b0), .CNT_W(2)) u_cnt2 (
    .clk(clk), .n_rst(n_rst), .req_if(ifc_c.slave), .s(s_c), .r(r_c), .q_fb(q_c),
    .err_clr(err_clr), .busy(busy_c), .err(err_c), .cmd_cnt(cmd_c), .skip_cnt(skip_c));

  // Flop models: storing flop for pulse mode, s-follower for hold mode.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q_m <= 1'b0;
      q_c <= 1'b0;
      q_h <= 1'b0;
    end else begin
      if (s_m) q_m <= 1'b1;
      else if (r_m) q_m <= 1'b0;
      if (s_c) q_c <= 1'b1;
      else if (r_c) q_c <= 1'b0;
      q_h <= s_h;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic lvl;
    int   qsel;
    bit   clr_chk;
    bit   clr_after;
    int   cmd, skip, err, lat, s_cyc, r_cyc, c2cmd, c2skip, h_r;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int overlap = 0;
  bit mon_en = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic vec_t mk(input logic lvl, input int qsel, input bit clr_chk,
                              input bit clr_after, input int cmd, input int skip,
                              input int err, input int lat, input int s_cyc,
                              input int r_cyc, input int c2cmd, input int c2skip,
                              input int h_r);
    vec_t v;
    v.lvl = lvl; v.qsel = qsel; v.clr_chk = clr_chk; v.clr_after = clr_after;
    v.cmd = cmd; v.skip = skip; v.err = err; v.lat = lat; v.s_cyc = s_cyc;
    v.r_cyc = r_cyc; v.c2cmd = c2cmd; v.c2skip = c2skip; v.h_r = h_r;
    return v;
  endfunction

  // Monitor
  bit in_txn = 1'b0;
  int lat, s_cyc, r_cyc, h_r, h_bad;

  always @(negedge clk) begin
    if ((s_m && r_m) || (s_h && r_h) || (s_c && r_c)) overlap++;
    if (mon_en && n_rst) begin
      if (!in_txn) begin
        if (ifc_m.req_valid && ifc_m.req_ready) begin
          in_txn = 1'b1;
          lat = 0; s_cyc = 0; r_cyc = 0; h_r = 0; h_bad = 0;
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow: got accept, expected no request pending");
            in_txn = 1'b0;
          end
        end
      end else begin
        lat++;
        if (s_m) s_cyc++;
        if (r_m) r_cyc++;
        if (r_h) h_r++;
        if (s_h != sb[0].lvl) h_bad++;
        if (ifc_m.req_ready || lat > 30) begin
          vec_t e;
          e = sb.pop_front();
          chk("latency", lat, e.lat);
          chk("s_cycles", s_cyc, e.s_cyc);
          chk("r_cycles", r_cyc, e.r_cyc);
          chk("cmd_cnt", int'(cmd_m), e.cmd);
          chk("skip_cnt", int'(skip_m), e.skip);
          chk("err", int'(err_m), e.err);
          chk("cnt2_cmd_cnt", int'(cmd_c), e.c2cmd);
          chk("cnt2_skip_cnt", int'(skip_c), e.c2skip);
          chk("hold_s_level_miss", h_bad, 0);
          chk("hold_r_cycles", h_r, e.h_r);
          in_txn = 1'b0;
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    q_sel = v.qsel;
    sb.push_back(v);
    @(posedge clk); #1;
    ifc_m.req_valid = 1'b1;
    ifc_m.req_level = v.lvl;
    n = 0;
    while (!ifc_m.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      $display("FAIL ready_timeout: got req_ready=0 for %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    ifc_m.req_valid = 1'b0;
    if (v.clr_chk) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    q_sel = 0;
    if (v.clr_after) begin
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("err_after_clr", int'(err_m), 0);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    err_clr = 1'b0;
    q_sel = 0;
    ifc_m.req_valid = 1'b0;
    ifc_m.req_level = 1'b0;

    //          lvl  qs clrc clra cmd skp err lat s r c2c c2s hr
    vecs.push_back(mk(1'b1, 0, 0, 0, 1, 0, 0, 5, 2, 0, 1, 0, 0));
    vecs.push_back(mk(1'b1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1'b0, 1, 0, 1, 2, 1, 1, 5, 0, 2, 2, 1, 2));
    vecs.push_back(mk(1'b1, 0, 0, 0, 3, 1, 0, 5, 2, 0, 3, 1, 0));
    vecs.push_back(mk(1'b0, 0, 0, 0, 4, 1, 0, 5, 0, 2, 0, 1, 2));
    vecs.push_back(mk(1'b1, 0, 0, 0, 5, 1, 0, 5, 2, 0, 1, 1, 0));
    vecs.push_back(mk(1'b0, 0, 0, 0, 6, 1, 0, 5, 0, 2, 2, 1, 2));
    vecs.push_back(mk(1'b0, 0, 0, 0, 6, 2, 0, 1, 0, 0, 2, 2, 0));
    vecs.push_back(mk(1'b1, 2, 1, 0, 7, 2, 1, 5, 2, 0, 3, 2, 0));

    repeat (3) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_s", int'(s_m), 0);
    chk("rst_r", int'(r_m), 0);
    chk("rst_busy", int'(busy_m), 0);
    chk("rst_err", int'(err_m), 0);
    chk("rst_cmd_cnt", int'(cmd_m), 0);
    chk("rst_skip_cnt", int'(skip_m), 0);
    chk("rst_req_ready", int'(ifc_m.req_ready), 1);

    // Reset asserted in the middle of a set pulse.
    ifc_m.req_valid = 1'b1;
    ifc_m.req_level = 1'b1;
    @(posedge clk); #1;
    ifc_m.req_valid = 1'b0;
    chk("midpulse_s", int'(s_m), 1);
    chk("midpulse_hold_s", int'(s_h), 1);
    chk("midpulse_busy", int'(busy_m), 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("abort_s", int'(s_m), 0);
    chk("abort_r", int'(r_m), 0);
    chk("abort_hold_s", int'(s_h), 0);
    chk("abort_busy", int'(busy_m), 0);
    chk("abort_cmd_cnt", int'(cmd_m), 0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    chk("release_req_ready", int'(ifc_m.req_ready), 1);
    chk("release_busy", int'(busy_m), 0);

    mon_en = 1'b1;
    foreach (vecs[i]) send(vecs[i]);

    chk("sb_drained", sb.size(), 0);
    chk("s_r_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
